emmc_card_cmd_resp: RTL and testbench

Card-side CMD-line responder for eMMC: receives 48-bit host command frames, checks them, tracks the card identification/transfer state, and drives R1/R1b/R2/R3 responses back on the CMD line. It is the device end of the host command path and serves as the card model in host-side benches and as the command front end of a future card emulator. Data-phase requests (CMD8/17/24) are forwarded to a separate data responder through a strobe.

---
 rtl/emmc_card_cmd_resp.sv | 335 +++++++++++++++++++++++++++++++++
 tb/tb_emmc_card_cmd_resp.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/emmc_card_cmd_resp.sv
// emmc_card_cmd_resp
//   Card-side eMMC CMD-line responder. It receives 48-bit host command
//   frames, checks them, tracks the card identification/transfer state and
//   drives R1/R1b/R2/R3 responses back on the CMD line. Data commands
//   (CMD8/17/24) are handed to a separate data responder via dat_req_o.
//
// Ports
//   clk_i         sole clock, rising edge
//   rst_i         synchronous active-high reset
//   cmd_i         CMD line from host
//   cmd_o/_oe_o   response bit and its drive enable
//   busy_o        DAT0 busy request after an R1b response
//   dat_req_o     one-cycle pulse after the R1 of an accepted CMD8/17/24
//   dat_idx_o     index of the last data command (held)
//   dat_arg_o     argument of the last data command (held)
//   card_state_o  current card state (status-register encoding)
//   rca_o         assigned relative card address
//
// Build option
//   EMMC_CARD_CRC_CHECK_EN : when defined, commands with a bad CRC7 are
//   dropped and COM_CRC_ERROR (bit 23) is flagged in the next R1.
module emmc_card_cmd_resp #(
  parameter logic [31:0]  OCR         = 32'h40FF8080,
  parameter int           BUSY_POLLS  = 2,
  parameter logic [127:0] CID         = 128'h7000_0000_454D_4D43_3031_1234_5678_9A01,
  parameter logic [127:0] CSD         = 128'hD00F_0032_0F59_03FF_FFFF_FFFF_8A40_4001,
  parameter int           NCR         = 2,
  parameter int           BUSY_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_i,
  output logic        cmd_o,
  output logic        cmd_oe_o,
  output logic        busy_o,
  output logic        dat_req_o,
  output logic [5:0]  dat_idx_o,
  output logic [31:0] dat_arg_o,
  output logic [3:0]  card_state_o,
  output logic [15:0] rca_o
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_READY = 4'd1, S_IDENT = 4'd2, S_STBY = 4'd3, S_TRAN = 4'd4
  } card_st_e;
  typedef enum logic [1:0] {R_IDLE, R_SHIFT, R_CHECK} rx_st_e;
  typedef enum logic [1:0] {T_IDLE, T_WAIT, T_SEND} tx_st_e;
  typedef enum logic [2:0] {K_NONE, K_R1, K_R3, K_R2CID, K_R2CSD} kind_e;
  typedef enum logic [1:0] {A_NONE, A_BUSY, A_DAT} act_e;

  // CRC7 (x^7 + x^3 + 1), MSB first
  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [6:0] crc7_120(input logic [119:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 119; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  rx_st_e         rx_st_q, rx_st_d;
  tx_st_e         tx_st_q, tx_st_d;
  logic [47:0]    rx_sh_q;
  logic [5:0]     rx_cnt_q;
  card_st_e       state_q, pend_state_q;
  logic [15:0]    rca_q, pend_rca_q;
  logic [7:0]     poll_q;
  logic           err_ill_q, err_crc_q;
  logic [135:0]   resp_q;
  logic           long_q;
  act_e           pend_act_q;
  logic [5:0]     pend_idx_q;
  logic [31:0]    pend_arg_q;
  logic [5:0]     tx_cnt_q;
  logic [7:0]     bits_q;
  logic           cmd_o_q, cmd_oe_q, busy_q, dat_req_q;
  logic [15:0]    busy_cnt_q;
  logic [5:0]     dat_idx_q;
  logic [31:0]    dat_arg_q;

  // received frame fields (valid while rx_st_q == R_CHECK)
  logic        rx_dir, rx_end, crc_ok, rca_hit;
  logic [5:0]  rx_idx;
  logic [31:0] rx_arg;
  assign rx_dir  = rx_sh_q[46];
  assign rx_idx  = rx_sh_q[45:40];
  assign rx_arg  = rx_sh_q[39:8];
  assign rx_end  = rx_sh_q[0];
  assign rca_hit = (rx_arg[31:16] == rca_q);

`ifdef EMMC_CARD_CRC_CHECK_EN
  assign crc_ok = (crc7_40(rx_sh_q[47:8]) == rx_sh_q[7:1]);
`else
  logic unused_rx_crc;
  assign unused_rx_crc = ^rx_sh_q[7:1];
  assign crc_ok = 1'b1;
`endif

  // command decode
  kind_e    kind;
  act_e     act;
  card_st_e nst;
  logic [15:0] nrca;
  logic     set_ill, set_crc, do_cmd0, poll_inc, ocr_rdy;

  always_comb begin
    kind     = K_NONE;
    act      = A_NONE;
    nst      = state_q;
    nrca     = rca_q;
    set_ill  = 1'b0;
    set_crc  = 1'b0;
    do_cmd0  = 1'b0;
    poll_inc = 1'b0;
    ocr_rdy  = 1'b0;
    if (rx_st_q == R_CHECK && rx_dir && rx_end) begin
      if (!crc_ok) set_crc = 1'b1;
      else begin
        case (rx_idx)
          6'd0: do_cmd0 = 1'b1;
          6'd1:
            if (state_q == S_IDLE || state_q == S_READY) begin
              kind = K_R3;
              if (poll_q >= 8'(BUSY_POLLS)) begin
                ocr_rdy = 1'b1;
                nst     = S_READY;
              end else poll_inc = 1'b1;
            end else set_ill = 1'b1;
          6'd2:
            if (state_q == S_READY) begin
              kind = K_R2CID;
              nst  = S_IDENT;
            end else set_ill = 1'b1;
          6'd3:
            if (state_q == S_IDENT) begin
              kind = K_R1;
              nrca = rx_arg[31:16];
              nst  = S_STBY;
            end else set_ill = 1'b1;
          6'd9:
            if (state_q == S_STBY && rca_hit) kind = K_R2CSD;
            else set_ill = 1'b1;
          6'd7:
            if (state_q == S_STBY && rca_hit) begin
              kind = K_R1;
              nst  = S_TRAN;
            end else set_ill = 1'b1;
          6'd6:
            if (state_q == S_TRAN) begin
              kind = K_R1;
              act  = A_BUSY;
            end else set_ill = 1'b1;
          6'd8, 6'd17, 6'd24:
            if (state_q == S_TRAN) begin
              kind = K_R1;
              act  = A_DAT;
            end else set_ill = 1'b1;
          default: set_ill = 1'b1;
        endcase
      end
    end
  end

  // response frames, left-aligned in 136 bits
  logic [31:0]  status;
  logic [39:0]  r1_body;
  logic [135:0] resp_d;
  assign status  = {8'h00, err_crc_q, err_ill_q, 9'h000, state_q, 1'b1, 8'h00};
  assign r1_body = {2'b00, rx_idx, status};

  always_comb begin
    resp_d = '0;
    case (kind)
      K_R1:    resp_d = {r1_body, crc7_40(r1_body), 1'b1, 88'h0};
      K_R3:    resp_d = {2'b00, 6'h3F, ocr_rdy, OCR[30:0], 7'h7F, 1'b1, 88'h0};
      K_R2CID: resp_d = {2'b00, 6'h3F, CID[127:8], crc7_120(CID[127:8]), 1'b1};
      K_R2CSD: resp_d = {2'b00, 6'h3F, CSD[127:8], crc7_120(CSD[127:8]), 1'b1};
      default: resp_d = '0;
    endcase
  end

  // FSM next state; RX only arms while nothing is being transmitted
  always_comb begin
    rx_st_d = rx_st_q;
    tx_st_d = tx_st_q;
    case (rx_st_q)
      R_IDLE:  if (tx_st_q == T_IDLE && !cmd_i) rx_st_d = R_SHIFT;
      R_SHIFT: if (rx_cnt_q == 6'd1) rx_st_d = R_CHECK;
      default: rx_st_d = R_IDLE;
    endcase
    case (tx_st_q)
      T_IDLE:  if (kind != K_NONE) tx_st_d = T_WAIT;
      T_WAIT:  if (tx_cnt_q == 6'd0) tx_st_d = T_SEND;
      T_SEND:  if (bits_q == 8'd0) tx_st_d = T_IDLE;
      default: tx_st_d = T_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_st_q <= R_IDLE;
      tx_st_q <= T_IDLE;
    end else begin
      rx_st_q <= rx_st_d;
      tx_st_q <= tx_st_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_sh_q      <= '0;
      rx_cnt_q     <= '0;
      state_q      <= S_IDLE;
      pend_state_q <= S_IDLE;
      rca_q        <= 16'h0001;
      pend_rca_q   <= 16'h0001;
      poll_q       <= '0;
      err_ill_q    <= 1'b0;
      err_crc_q    <= 1'b0;
      resp_q       <= '0;
      long_q       <= 1'b0;
      pend_act_q   <= A_NONE;
      pend_idx_q   <= '0;
      pend_arg_q   <= '0;
      tx_cnt_q     <= '0;
      bits_q       <= '0;
      cmd_o_q      <= 1'b1;
      cmd_oe_q     <= 1'b0;
      busy_q       <= 1'b0;
      busy_cnt_q   <= '0;
      dat_req_q    <= 1'b0;
      dat_idx_q    <= '0;
      dat_arg_q    <= '0;
    end else begin
      dat_req_q <= 1'b0;

      // start bit is already 0, so the frame begins as all zeros
      if (rx_st_q == R_IDLE && rx_st_d == R_SHIFT) begin
        rx_sh_q  <= '0;
        rx_cnt_q <= 6'd47;
      end else if (rx_st_q == R_SHIFT) begin
        rx_sh_q  <= {rx_sh_q[46:0], cmd_i};
        rx_cnt_q <= rx_cnt_q - 6'd1;
      end

      // errors are reported once, then cleared
      if (kind == K_R1) begin
        err_ill_q <= 1'b0;
        err_crc_q <= 1'b0;
      end
      if (set_ill) err_ill_q <= 1'b1;
      if (set_crc) err_crc_q <= 1'b1;
      if (poll_inc) poll_q <= poll_q + 8'd1;
      if (do_cmd0) begin
        state_q <= S_IDLE;
        rca_q   <= 16'h0001;
        poll_q  <= '0;
      end

      if (busy_q) begin
        if (busy_cnt_q == 16'd0) busy_q <= 1'b0;
        else busy_cnt_q <= busy_cnt_q - 16'd1;
      end

      case (tx_st_q)
        T_IDLE:
          if (kind != K_NONE) begin
            resp_q       <= resp_d;
            long_q       <= (kind == K_R2CID) || (kind == K_R2CSD);
            pend_state_q <= nst;
            pend_rca_q   <= nrca;
            pend_act_q   <= act;
            pend_idx_q   <= rx_idx;
            pend_arg_q   <= rx_arg;
            // the check cycle itself is one of the NCR gap cycles
            tx_cnt_q     <= 6'(NCR - 2);
          end
        T_WAIT:
          if (tx_cnt_q == 6'd0) begin
            cmd_oe_q <= 1'b1;
            cmd_o_q  <= resp_q[135];
            resp_q   <= {resp_q[134:0], 1'b0};
            bits_q   <= long_q ? 8'd135 : 8'd47;
            // state/RCA become visible together with the start bit
            state_q  <= pend_state_q;
            rca_q    <= pend_rca_q;
          end else tx_cnt_q <= tx_cnt_q - 6'd1;
        T_SEND:
          if (bits_q == 8'd0) begin
            cmd_oe_q <= 1'b0;
            cmd_o_q  <= 1'b1;
            if (pend_act_q == A_BUSY) begin
              busy_q     <= 1'b1;
              busy_cnt_q <= 16'(BUSY_CYCLES - 1);
            end
            if (pend_act_q == A_DAT) begin
              dat_req_q <= 1'b1;
              dat_idx_q <= pend_idx_q;
              dat_arg_q <= pend_arg_q;
            end
          end else begin
            cmd_o_q <= resp_q[135];
            resp_q  <= {resp_q[134:0], 1'b0};
            bits_q  <= bits_q - 8'd1;
          end
        default: ;
      endcase
    end
  end

  assign cmd_o        = cmd_o_q;
  assign cmd_oe_o     = cmd_oe_q;
  assign busy_o       = busy_q;
  assign dat_req_o    = dat_req_q;
  assign dat_idx_o    = dat_idx_q;
  assign dat_arg_o    = dat_arg_q;
  assign card_state_o = state_q;
  assign rca_o        = rca_q;

endmodule

// File: tb/tb_emmc_card_cmd_resp.sv
module tb_emmc_card_cmd_resp;
  localparam logic [31:0]  OCR         = 32'h40FF8080;
  localparam int           BUSY_POLLS  = 2;
  localparam logic [127:0] CID         = 128'h7000_0000_454D_4D43_3031_1234_5678_9A01;
  localparam logic [127:0] CSD         = 128'hD00F_0032_0F59_03FF_FFFF_FFFF_8A40_4001;
  localparam int           NCR         = 2;
  localparam int           BUSY_CYCLES = 16;
`ifdef EMMC_CARD_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_i, cmd_i;
  logic cmd_o, cmd_oe_o, busy_o, dat_req_o;
  logic [5:0]  dat_idx_o;
  logic [31:0] dat_arg_o;
  logic [3:0]  card_state_o;
  logic [15:0] rca_o;

  always #5 clk = ~clk;

  emmc_card_cmd_resp #(
    .OCR(OCR), .BUSY_POLLS(BUSY_POLLS), .CID(CID), .CSD(CSD),
    .NCR(NCR), .BUSY_CYCLES(BUSY_CYCLES)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .cmd_i(cmd_i), .cmd_o(cmd_o),
    .cmd_oe_o(cmd_oe_o), .busy_o(busy_o), .dat_req_o(dat_req_o),
    .dat_idx_o(dat_idx_o), .dat_arg_o(dat_arg_o),
    .card_state_o(card_state_o), .rca_o(rca_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference card model
  int          m_state;
  logic [15:0] m_rca;
  int          m_polls;
  bit          m_ill, m_crcerr;
  logic [5:0]  m_didx;
  logic [31:0] m_darg;

  // captured response
  int           len, lat, bsy;
  logic [135:0] bits;
  bit           dreq;
  logic [3:0]   sb, ss;
  // expected response
  int           e_len, e_act;
  logic [135:0] e_bits;

  // CRC7 as polynomial long division of msg(lowest nbits) * x^7 by 0x89
  function automatic logic [6:0] ref_crc(input logic [119:0] msg, input int nbits);
    logic [126:0] r;
    r = {msg, 7'b0};
    for (int i = nbits + 6; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  task automatic model_reset();
    m_state = 0; m_rca = 16'h0001; m_polls = 0; m_ill = 0; m_crcerr = 0;
    m_didx = '0; m_darg = '0;
  endtask

  task automatic model_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit crc_good,
                           input bit dir, input bit endb,
                           output int o_len, output logic [135:0] o_bits, output int o_act);
    logic [31:0] st;
    logic [39:0] body;
    bit r1, rdy;
    o_len = 0; o_bits = '0; o_act = 0; r1 = 0;
    st = '0; st[12:9] = 4'(m_state); st[8] = 1'b1; st[22] = m_ill; st[23] = m_crcerr;
    if (dir && endb) begin
      if (!crc_good && CRC_EN) m_crcerr = 1;
      else if (idx == 0) begin m_state = 0; m_rca = 16'h0001; m_polls = 0; end
      else if (idx == 1 && m_state <= 1) begin
        rdy = (m_polls >= BUSY_POLLS);
        if (rdy) m_state = 1; else m_polls++;
        o_len = 48; o_bits = {2'b00, 6'h3F, rdy, OCR[30:0], 7'h7F, 1'b1, 88'h0};
      end else if (idx == 2 && m_state == 1) begin
        o_len = 136; o_bits = {2'b00, 6'h3F, CID[127:8], ref_crc(CID[127:8], 120), 1'b1};
        m_state = 2;
      end else if (idx == 3 && m_state == 2) begin
        r1 = 1; m_rca = arg[31:16]; m_state = 3;
      end else if (idx == 9 && m_state == 3 && arg[31:16] == m_rca) begin
        o_len = 136; o_bits = {2'b00, 6'h3F, CSD[127:8], ref_crc(CSD[127:8], 120), 1'b1};
      end else if (idx == 7 && m_state == 3 && arg[31:16] == m_rca) begin
        r1 = 1; m_state = 4;
      end else if (idx == 6 && m_state == 4) begin
        r1 = 1; o_act = 1;
      end else if ((idx == 8 || idx == 17 || idx == 24) && m_state == 4) begin
        r1 = 1; o_act = 2; m_didx = idx; m_darg = arg;
      end else m_ill = 1;
      if (r1) begin
        body = {2'b00, idx, st};
        o_len = 48; o_bits = {body, ref_crc(120'(body), 40), 1'b1, 88'h0};
        m_ill = 0; m_crcerr = 0;
      end
    end
  endtask

  task automatic send_frame(input logic [5:0] idx, input logic [31:0] arg, input bit bad_crc,
                            input bit dir, input bit endb);
    logic [39:0] h;
    logic [47:0] f;
    h = {1'b0, dir, idx, arg};
    f = {h, ref_crc(120'(h), 40) ^ (bad_crc ? 7'h7F : 7'h00), endb};
    for (int i = 47; i >= 0; i--) begin
      @(negedge clk); cmd_i = f[i];
    end
    @(negedge clk); cmd_i = 1'b1;   // end bit has just been sampled
  endtask

  // sends a frame and records whatever the card answers (bounded waits)
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit bad_crc,
                         input bit dir, input bit endb);
    int k;
    logic [3:0] prev;
    send_frame(idx, arg, bad_crc, dir, endb);
    len = 0; bits = '0; lat = -1; dreq = 0; bsy = 0; sb = 'x; ss = 'x;
    k = 0; prev = card_state_o;
    while (!cmd_oe_o && k < NCR + 12) begin
      prev = card_state_o; @(negedge clk); k++;
    end
    if (cmd_oe_o) begin
      lat = k; sb = prev; ss = card_state_o;
      while (cmd_oe_o && len < 140) begin
        if (len < 136) bits[135 - len] = cmd_o;
        len++; @(negedge clk);
      end
      dreq = dat_req_o;
      while (busy_o && bsy < 100) begin bsy++; @(negedge clk); end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; cmd_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    model_reset();
    n_cmp++; if (cmd_o !== 1'b1)        begin n_bad++; $display("FAIL reset_cmd_o: got %b want 1", cmd_o); end
    n_cmp++; if (cmd_oe_o !== 1'b0)     begin n_bad++; $display("FAIL reset_oe: got %b want 0", cmd_oe_o); end
    n_cmp++; if (busy_o !== 1'b0)       begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_cmp++; if (dat_req_o !== 1'b0)    begin n_bad++; $display("FAIL reset_dreq: got %b want 0", dat_req_o); end
    n_cmp++; if (dat_idx_o !== 6'd0)    begin n_bad++; $display("FAIL reset_didx: got %0d want 0", dat_idx_o); end
    n_cmp++; if (dat_arg_o !== 32'd0)   begin n_bad++; $display("FAIL reset_darg: got %h want 0", dat_arg_o); end
    n_cmp++; if (card_state_o !== 4'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", card_state_o); end
    n_cmp++; if (rca_o !== 16'h0001)    begin n_bad++; $display("FAIL reset_rca: got %h want 0001", rca_o); end
  endtask

  task automatic test_ident();
    logic [31:0] want;
    model_cmd(6'd0, 32'h0, 1, 1, 1, e_len, e_bits, e_act);
    run_cmd(6'd0, 32'h0, 0, 1, 1);
    n_cmp++; if (len !== 0) begin n_bad++; $display("FAIL cmd0_noresp: got len %0d want 0", len); end
    for (int i = 0; i < 3; i++) begin
      model_cmd(6'd1, 32'h40FF8080, 1, 1, 1, e_len, e_bits, e_act);
      run_cmd(6'd1, 32'h40FF8080, 0, 1, 1);
      want = (i < 2) ? 32'h40FF8080 : 32'hC0FF8080;
      n_cmp++; if (len !== 48 || bits !== e_bits)
        begin n_bad++; $display("FAIL cmd1_r3[%0d]: got len %0d %h want len 48 %h", i, len, bits, e_bits); end
      n_cmp++; if (bits[127:96] !== want) begin n_bad++; $display("FAIL cmd1_ocr[%0d]: got %h want %h", i, bits[127:96], want); end
      n_cmp++; if (lat !== NCR) begin n_bad++; $display("FAIL cmd1_ncr[%0d]: got %0d want %0d", i, lat, NCR); end
    end
    n_cmp++; if (card_state_o !== 4'd1) begin n_bad++; $display("FAIL cmd1_state: got %0d want 1", card_state_o); end

    model_cmd(6'd2, 32'h0, 1, 1, 1, e_len, e_bits, e_act);
    run_cmd(6'd2, 32'h0, 0, 1, 1);
    n_cmp++; if (len !== 136 || bits !== e_bits)
      begin n_bad++; $display("FAIL cmd2_r2: got len %0d %h want len 136 %h", len, bits, e_bits); end
    n_cmp++; if (sb !== 4'd1 || ss !== 4'd2)
      begin n_bad++; $display("FAIL cmd2_state_edge: got %0d->%0d want 1->2", sb, ss); end

    model_cmd(6'd3, 32'h00040000, 1, 1, 1, e_len, e_bits, e_act);
    run_cmd(6'd3, 32'h00040000, 0, 1, 1);
    n_cmp++; if (len !== 48 || bits !== e_bits)
      begin n_bad++; $display("FAIL cmd3_r1: got len %0d %h want %h", len, bits, e_bits); end
    n_cmp++; if (bits[108:105] !== 4'd2) begin n_bad++; $display("FAIL cmd3_curstate: got %0d want 2", bits[108:105]); end
    n_cmp++; if (rca_o !== 16'h0004) begin n_bad++; $display("FAIL cmd3_rca: got %h want 0004", rca_o); end
    n_cmp++; if (card_state_o !== 4'd3) begin n_bad++; $display("FAIL cmd3_state: got %0d want 3", card_state_o); end
  endtask

  task automatic test_illegal();
    model_cmd(6'd9, 32'h00050000, 1, 1, 1, e_len, e_bits, e_act);
    run_cmd(6'd9, 32'h00050000, 0, 1, 1);
    n_cmp++; if (len !== 0) begin n_bad++; $display("FAIL cmd9_badrca: got len %0d want 0", len); end
    n_cmp++; if (card_state_o !== 4'd3) begin n_bad++; $display("FAIL cmd9_state: got %0d want 3", card_state_o); end
    model_cmd(6'd7, 32'h00040000, 1, 1, 1, e_len, e_bits, e_act);
    run_cmd(6'd7, 32'h00040000, 0, 1, 1);
    n_cmp++; if (len !== 48 || bits !== e_bits)
      begin n_bad++; $display("FAIL cmd7_r1: got len %0d %h want %h", len, bits, e_bits); end
    n_cmp++; if (bits[118] !== 1'b1) begin n_bad++; $display("FAIL cmd7_illegal_bit: got %b want 1", bits[118]); end
    n_cmp++; if (card_state_o !== 4'd4) begin n_bad++; $display("FAIL cmd7_state: got %0d want 4", card_state_o); end
  endtask

  task automatic test_busy();
    model_cmd(6'd6, 32'h03B70200, 1, 1, 1, e_len, e_bits, e_act);
    run_cmd(6'd6, 32'h03B70200, 0, 1, 1);
    n_cmp++; if (len !== 48 || bits !== e_bits)
      begin n_bad++; $display("FAIL cmd6_r1b: got len %0d %h want %h", len, bits, e_bits); end
    n_cmp++; if (bsy !== BUSY_CYCLES) begin n_bad++; $display("FAIL cmd6_busy_len: got %0d want %0d", bsy, BUSY_CYCLES); end
  endtask

  task automatic test_data();
    model_cmd(6'd17, 32'h10, 1, 1, 1, e_len, e_bits, e_act);
    run_cmd(6'd17, 32'h10, 0, 1, 1);
    n_cmp++; if (len !== 48 || bits !== e_bits)
      begin n_bad++; $display("FAIL cmd17_r1: got len %0d %h want %h", len, bits, e_bits); end
    n_cmp++; if (dreq !== 1'b1) begin n_bad++; $display("FAIL cmd17_dreq: got %b want 1", dreq); end
    n_cmp++; if (dat_idx_o !== 6'd17 || dat_arg_o !== 32'h10)
      begin n_bad++; $display("FAIL cmd17_dat: got %0d/%h want 17/00000010", dat_idx_o, dat_arg_o); end
    @(negedge clk);
    n_cmp++; if (dat_req_o !== 1'b0) begin n_bad++; $display("FAIL cmd17_dreq_width: got %b want 0", dat_req_o); end
  endtask

  task automatic test_crc();
    logic [31:0] a;
    model_cmd(6'd7, 32'h00040000, 0, 1, 1, e_len, e_bits, e_act);
    run_cmd(6'd7, 32'h00040000, 1, 1, 1);
    n_cmp++; if (len !== 0) begin n_bad++; $display("FAIL crc_bad_noresp: got len %0d want 0", len); end
    a = $urandom;
    model_cmd(6'd17, a, 1, 1, 1, e_len, e_bits, e_act);
    run_cmd(6'd17, a, 0, 1, 1);
    n_cmp++; if (len !== 48 || bits !== e_bits)
      begin n_bad++; $display("FAIL crc_next_r1: got len %0d %h want %h", len, bits, e_bits); end
    n_cmp++; if (bits[119] !== CRC_EN || bits[118] !== !CRC_EN)
      begin n_bad++; $display("FAIL crc_err_bits: got b23=%b b22=%b want b23=%b", bits[119], bits[118], CRC_EN); end
  endtask

  task automatic test_random();
    logic [5:0]  idx_tab [8];
    logic [5:0]  idx;
    logic [31:0] a;
    bit bad, dir, endb;
    idx_tab = '{6'd6, 6'd8, 6'd17, 6'd24, 6'd7, 6'd9, 6'd13, 6'd55};
    for (int n = 0; n < 24; n++) begin
      idx  = idx_tab[$urandom_range(0, 7)];
      a    = $urandom;
      bad  = ($urandom_range(0, 4) == 0);
      dir  = ($urandom_range(0, 9) != 0);
      endb = ($urandom_range(0, 9) != 0);
      model_cmd(idx, a, !bad, dir, endb, e_len, e_bits, e_act);
      run_cmd(idx, a, bad, dir, endb);
      n_cmp++; if (len !== e_len || bits !== e_bits)
        begin n_bad++; $display("FAIL rnd_resp[%0d] cmd%0d: got len %0d %h want len %0d %h", n, idx, len, bits, e_len, e_bits); end
      n_cmp++; if (e_len != 0 && lat !== NCR)
        begin n_bad++; $display("FAIL rnd_ncr[%0d]: got %0d want %0d", n, lat, NCR); end
      n_cmp++; if (dreq !== (e_act == 2) || bsy !== ((e_act == 1) ? BUSY_CYCLES : 0))
        begin n_bad++; $display("FAIL rnd_side[%0d]: got dreq %b busy %0d want act %0d", n, dreq, bsy, e_act); end
      n_cmp++; if (dat_idx_o !== m_didx || dat_arg_o !== m_darg || card_state_o !== 4'(m_state))
        begin n_bad++; $display("FAIL rnd_regs[%0d]: got %0d/%h st %0d want %0d/%h st %0d", n, dat_idx_o, dat_arg_o, card_state_o, m_didx, m_darg, m_state); end
    end
  endtask

  task automatic test_reset_mid();
    int k, n;
    model_cmd(6'd0, 32'h0, 1, 1, 1, e_len, e_bits, e_act);
    run_cmd(6'd0, 32'h0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      model_cmd(6'd1, 32'h0, 1, 1, 1, e_len, e_bits, e_act);
      run_cmd(6'd1, 32'h0, 0, 1, 1);
    end
    send_frame(6'd2, 32'h0, 0, 1, 1);
    k = 0;
    while (!cmd_oe_o && k < NCR + 12) begin @(negedge clk); k++; end
    n_cmp++; if (cmd_oe_o !== 1'b1) begin n_bad++; $display("FAIL rstmid_r2_start: got oe %b want 1", cmd_oe_o); end
    n = 1;
    while (n < 60 && cmd_oe_o) begin @(negedge clk); n++; end
    rst_i = 1'b1;
    @(negedge clk);
    n_cmp++; if (cmd_oe_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_oe: got %b want 0", cmd_oe_o); end
    n_cmp++; if (card_state_o !== 4'd0 || rca_o !== 16'h0001)
      begin n_bad++; $display("FAIL rstmid_regs: got st %0d rca %h want 0/0001", card_state_o, rca_o); end
    rst_i = 1'b0;
    model_reset();
    @(negedge clk);
    model_cmd(6'd1, 32'h0, 1, 1, 1, e_len, e_bits, e_act);
    run_cmd(6'd1, 32'h0, 0, 1, 1);
    n_cmp++; if (len !== 48 || bits !== e_bits)
      begin n_bad++; $display("FAIL rstmid_cmd1: got len %0d %h want %h", len, bits, e_bits); end
  endtask

  initial begin
    rst_i = 1'b1; cmd_i = 1'b1;
    model_reset();
    test_reset();
    test_ident();
    test_illegal();
    test_busy();
    test_data();
    test_crc();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
